game_fsm: RTL and testbench

//  Top-level game-flow controller for the console: a Moore FSM tracking START, PLAYING, PAUSE,

---
 rtl/game_fsm_pkg.sv | 13 +
 rtl/game_fsm.sv | 67 ++++++
 tb/tb_game_fsm.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/game_fsm_pkg.sv
// State codes for the game-flow controller. Consumers that decode stateGame use these
// constants.
package game_fsm_pkg;

  localparam int unsigned StateWidth = 3;

  localparam logic [StateWidth-1:0] ST_START    = 3'b000;
  localparam logic [StateWidth-1:0] ST_PLAYING  = 3'b001;
  localparam logic [StateWidth-1:0] ST_PAUSE    = 3'b010;
  localparam logic [StateWidth-1:0] ST_RESET    = 3'b011;
  localparam logic [StateWidth-1:0] ST_GAMEOVER = 3'b100;

endpackage

// File: rtl/game_fsm.sv
// Game-flow Moore FSM: START, PLAYING, PAUSE, RESET and GAMEOVER driven by level control
// inputs. The registered state code is the only output.
module game_fsm
  import game_fsm_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetFSM,
  input  logic                  reset,
  input  logic                  startGame,
  input  logic                  pauseGame,
  input  logic                  dead,
  output logic [StateWidth-1:0] stateGame
);

  logic [StateWidth-1:0] state_q, state_d;
  logic                  reset_v, start_v, pause_v, dead_v;

  // Anything other than a clean 1 (X/Z from an undriven button) counts as not asserted.
  assign reset_v = (reset === 1'b1);
  assign start_v = (startGame === 1'b1);
  assign pause_v = (pauseGame === 1'b1);
  assign dead_v  = (dead === 1'b1);

  always_ff @(posedge clk) begin
    if (resetFSM) begin
      state_q <= ST_START;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = ST_START;
    case (state_q)
      ST_START: begin
        state_d = start_v ? ST_PLAYING : ST_START;
      end
      ST_PLAYING: begin
        if (dead_v)       state_d = ST_GAMEOVER;
        else if (reset_v) state_d = ST_RESET;
        else if (pause_v) state_d = ST_PAUSE;
        else              state_d = ST_PLAYING;
      end
      ST_PAUSE: begin
        if (reset_v)      state_d = ST_RESET;
        else if (start_v) state_d = ST_PLAYING;
        else              state_d = ST_PAUSE;
      end
      // RESET is shown for exactly one clock so downstream blocks reinitialise.
      ST_RESET: begin
        state_d = ST_START;
      end
      ST_GAMEOVER: begin
        state_d = (reset_v || start_v) ? ST_RESET : ST_GAMEOVER;
      end
      // Illegal codes (e.g. upset flops) recover to START.
      default: begin
        state_d = ST_START;
      end
    endcase
  end

  always_comb begin
    stateGame = state_q;
  end

endmodule

// File: tb/tb_game_fsm.sv
// Directed, table-driven bench for game_fsm with a few hand-written multi-cycle sequences.
module tb_game_fsm;

  logic       clk;
  logic       resetFSM;
  logic       reset;
  logic       startGame;
  logic       pauseGame;
  logic       dead;
  logic [2:0] stateGame;

  int checks;
  int failures;

  typedef struct {
    logic       rst_fsm;
    logic       rst;
    logic       start;
    logic       pause;
    logic       dd;
    logic [2:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[$];

  localparam logic [2:0] S0 = 3'b000;
  localparam logic [2:0] S1 = 3'b001;
  localparam logic [2:0] S2 = 3'b010;
  localparam logic [2:0] S3 = 3'b011;
  localparam logic [2:0] S4 = 3'b100;

  game_fsm dut (
    .clk       (clk),
    .resetFSM  (resetFSM),
    .reset     (reset),
    .startGame (startGame),
    .pauseGame (pauseGame),
    .dead      (dead),
    .stateGame (stateGame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic rf, input logic r, input logic s, input logic p, input logic d,
                     input logic [2:0] e, input string n);
    vec_t v;
    v.rst_fsm = rf; v.rst = r; v.start = s; v.pause = p; v.dd = d; v.exp = e; v.name = n;
    vecs.push_back(v);
  endtask

  // Drive inputs, take one rising edge, sample 1 time unit later.
  task automatic step(input logic rf, input logic r, input logic s, input logic p, input logic d,
                      input logic [2:0] e, input string n);
    resetFSM = rf; reset = r; startGame = s; pauseGame = p; dead = d;
    @(posedge clk);
    #1;
    checks++;
    if (stateGame !== e) begin
      failures++;
      $display("FAIL %s: stateGame=%b expected=%b", n, stateGame, e);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    resetFSM = 1'b0; reset = 1'b0; startGame = 1'b0; pauseGame = 1'b0; dead = 1'b0;
    @(posedge clk);
    #1;

    //   rf    r     s     p     d     exp
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S0, "fsm_reset");
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S0, "idle_0");
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S0, "idle_1");
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S0, "idle_2");
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S1, "start_to_play");
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S1, "hold_start_play");
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, S2, "play_to_pause");
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S1, "pause_resume");
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, S2, "play_to_pause_b");
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, S3, "pause_reset");
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S0, "reset_to_start");
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S1, "start_again");
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, S4, "play_dead");
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, S4, "over_pause_ign");
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, S4, "over_dead_ign");
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S3, "over_start");
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S0, "reset_one_cycle");
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S1, "start_c");
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, S4, "dead_wins");
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, S3, "over_reset");
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, S0, "reset_ign_inputs");
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, S0, "start_reset_ign");
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, S0, "start_pause_ign");
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, S0, "start_dead_ign");
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S1, "start_d");
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, S3, "play_reset_over_pause");
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S0, "reset_back");
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S1, "start_e");
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, S2, "play_pause_with_start");
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, S2, "pause_dead_ign");
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, S3, "pause_reset_over_start");
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S0, "reset_back_b");
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S1, "start_f");
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, S2, "pause_f");
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, S0, "fsm_reset_in_pause");
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S1, "start_g");
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, S4, "dead_g");
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, S0, "fsm_reset_in_over");

    foreach (vecs[i]) begin
      step(vecs[i].rst_fsm, vecs[i].rst, vecs[i].start, vecs[i].pause, vecs[i].dd,
           vecs[i].exp, vecs[i].name);
    end

    // Holding startGame as a level: PLAYING on the first edge and stays there.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S1, "hold_start_level");
    end

    // GAMEOVER with reset held high: RESET for exactly one clock, then START ignores reset.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, S4, "seq_dead");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, S3, "seq_over_reset");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, S0, "seq_reset_held");
    end

    // FSM reset held for several cycles wins over every request.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S1, "seq_play");
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, S0, "seq_fsm_reset_held");
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S0, "seq_after_fsm_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
